// File: rtl/addsub_pkg.sv
// addsub_pkg: shared types and helpers for the add/subtract self-test.
//   state_t        - sweep controller states
//   n_vec()        - number of {mode, a, b} vectors for a given operand width
//   addsub_expect()- golden {cbout, sum} for one vector, at any width up to MAX_W
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Widest operand the golden function handles; callers truncate the result.
    localparam int MAX_W = 16;

    function automatic int n_vec(input int width);
        return 1 << (2 * width + 1);
    endfunction

    // Returns {cbout, sum} in the low width+1 bits, upper bits zero.
    // Subtract reports a borrow (cbout=1 when a < b), not carry-not-borrow.
    function automatic logic [MAX_W:0] addsub_expect(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input logic             mode,
        input int               width
    );
        logic [MAX_W:0] sum_mask;
        logic [MAX_W:0] cb_bit;
        logic [MAX_W:0] raw;
        logic           cb;
        cb_bit   = (MAX_W+1)'(1) << width;
        sum_mask = cb_bit - (MAX_W+1)'(1);
        if (mode) begin
            raw = {1'b0, a} - {1'b0, b};
            cb  = (a < b);
        end else begin
            raw = {1'b0, a} + {1'b0, b};
            cb  = |(raw & cb_bit);
        end
        return (raw & sum_mask) | (cb ? cb_bit : '0);
    endfunction

endpackage

// File: rtl/addsub_bist_ref.sv
// addsub_ref: combinational golden model of the add/subtract unit.
//   a, b  (in)  operands
//   mode  (in)  0 = add, 1 = subtract
//   sum   (out) WIDTH-bit result
//   cbout (out) carry on add, borrow on subtract
module addsub_ref
    import addsub_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic [WIDTH-1:0] sum,
    output logic             cbout
);

    localparam int RW = WIDTH + 1;

    logic [WIDTH:0] res;

    // The cast drops the unused upper bits of the wide helper result.
    assign res          = RW'(addsub_expect(MAX_W'(a), MAX_W'(b), mode, WIDTH));
    assign {cbout, sum} = res;

endmodule

// File: rtl/addsub_bist.sv
// addsub_bist: sweeps every {mode, a, b} vector into a combinational
// add/subtract unit, checks each response against the golden model,
// counts mismatches (saturating) and captures the first failing vector.
//   clk, rst        clock, async active-high reset
//   start           one-cycle sweep request (ignored while busy)
//   a, b, mode      stimulus to the unit under test
//   sum, cbout      response from the unit under test
//   busy, done,pass sweep status; done/pass hold until next start or reset
//   err_count       mismatches in the last sweep
//   fail_valid,
//   fail_vec        first failing {mode, a, b}
module addsub_bist
    import addsub_pkg::*;
#(
    parameter int WIDTH         = 2,
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_W         = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [WIDTH-1:0]     a,
    output logic [WIDTH-1:0]     b,
    output logic                 mode,
    input  logic [WIDTH-1:0]     sum,
    input  logic                 cbout,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_W-1:0]     err_count,
    output logic                 fail_valid,
    output logic [2*WIDTH:0]     fail_vec
);

    localparam int          VW        = 2 * WIDTH + 1;
    localparam int          N         = n_vec(WIDTH);
    localparam logic [3:0]  HOLD_INIT = 4'(SETTLE_CYCLES);

    state_t          state, state_n;
    logic [VW-1:0]   vec;
    logic [3:0]      hold;
    logic [WIDTH-1:0] exp_sum;
    logic            exp_cbout;
    logic            compare;
    logic            mismatch;
    logic            last_vec;
    logic            launch;

    // Operands are the vector register itself, so they change right at the edge.
    assign {mode, a, b} = vec;

    addsub_ref #(.WIDTH(WIDTH)) u_ref (
        .a     (a),
        .b     (b),
        .mode  (mode),
        .sum   (exp_sum),
        .cbout (exp_cbout)
    );

    assign busy     = (state == APPLY);
    assign compare  = busy && (hold == 4'd0);
    assign mismatch = ({cbout, sum} != {exp_cbout, exp_sum});
    assign last_vec = (vec == VW'(N - 1));
    assign launch   = start && !busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = APPLY;
            APPLY:   if (compare && last_vec) state_n = DONE;
            DONE:    if (start) state_n = APPLY;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec        <= '0;
            hold       <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else if (launch) begin
            vec        <= '0;
            hold       <= HOLD_INIT;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else if (busy) begin
            if (hold != 4'd0) begin
                hold <= hold - 4'd1;
            end else begin
                if (mismatch) begin
                    if (err_count != '1) err_count <= err_count + 1'b1;
                    if (!fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_vec   <= vec;
                    end
                end
                if (last_vec) begin
                    done <= 1'b1;
                    // Fold in the final vector's result, not yet in err_count.
                    pass <= !mismatch && (err_count == '0);
                end else begin
                    vec  <= vec + 1'b1;
                    hold <= HOLD_INIT;
                end
            end
        end
    end

endmodule

// File: tb/tb_addsub_bist.sv
module tb_addsub_bist;

    logic clk = 1'b0;
    logic rst;
    logic start, start3;
    always #5 clk = ~clk;

    // default-parameter instance (WIDTH=2, SETTLE_CYCLES=1)
    logic [1:0] a, b, sum;
    logic       mode, cbout, busy, done, pass, fail_valid;
    logic [7:0] err_count;
    logic [4:0] fail_vec;

    // WIDTH=3, SETTLE_CYCLES=0 instance
    logic [2:0] a3, b3, sum3;
    logic       mode3, cbout3, busy3, done3, pass3, fail_valid3;
    logic [7:0] err_count3;
    logic [6:0] fail_vec3;

    // standalone golden model, checked with hand values
    logic [1:0] r_a, r_b, r_sum;
    logic       r_mode, r_cbout;

    int fault;  // 0 none, 1 sum[0] stuck 0, 2 cbout inverted on subtract
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    addsub_bist dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .mode(mode),
        .sum(sum), .cbout(cbout), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_valid(fail_valid), .fail_vec(fail_vec)
    );

    addsub_bist #(.WIDTH(3), .SETTLE_CYCLES(0), .ERR_W(8)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .mode(mode3),
        .sum(sum3), .cbout(cbout3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err_count3), .fail_valid(fail_valid3), .fail_vec(fail_vec3)
    );

    addsub_ref #(.WIDTH(2)) u_ref_chk (
        .a(r_a), .b(r_b), .mode(r_mode), .sum(r_sum), .cbout(r_cbout)
    );

    // Behavioural unit under test, built from plain operators plus faults.
    always_comb begin
        logic [2:0] t;
        t = mode ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
        sum   = t[1:0];
        cbout = t[2];
        if (fault == 1) sum[0] = 1'b0;
        if (fault == 2 && mode) cbout = ~t[2];
    end

    always_comb begin
        logic [3:0] t3;
        t3 = mode3 ? ({1'b0, a3} - {1'b0, b3}) : ({1'b0, a3} + {1'b0, b3});
        sum3   = t3[2:0];
        cbout3 = t3[3];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    typedef struct {
        int         lat;
        logic       pass;
        int         err;
        logic       fv;
        logic [4:0] fvec;
    } exp_t;

    exp_t q[$];

    // Monitor: tracks vector order, pops an expectation on each done rise.
    initial begin
        int   start_cyc;
        int   idx;
        logic done_q;
        bit   order_bad;
        exp_t e;
        start_cyc = 0;
        done_q    = 1'b0;
        order_bad = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                done_q = 1'b0;
            end else begin
                if (start && !busy) begin
                    start_cyc = cyc;
                    order_bad = 1'b0;
                end
                if (busy) begin
                    idx = (cyc - start_cyc - 1) / 2;
                    if ({mode, a, b} !== 5'(idx)) order_bad = 1'b1;
                end
                if (done && !done_q) begin
                    if (q.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("latency",    32'(cyc - start_cyc - 1), 32'(e.lat));
                        chk("pass",       32'(pass),       32'(e.pass));
                        chk("err_count",  32'(err_count),  32'(e.err));
                        chk("fail_valid", 32'(fail_valid), 32'(e.fv));
                        chk("fail_vec",   32'(fail_vec),   32'(e.fvec));
                        chk("vec_order",  32'(order_bad),  32'd0);
                    end
                end
                done_q = done;
            end
        end
    end

    task automatic push(input int lat, input logic p, input int err, input logic fv, input logic [4:0] fvec);
        exp_t e;
        e.lat = lat; e.pass = p; e.err = err; e.fv = fv; e.fvec = fvec;
        q.push_back(e);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) chk(name, 32'd0, 32'd1);
        @(negedge clk); #1;
    endtask

    task automatic ref_chk(input logic [1:0] ia, input logic [1:0] ib, input logic im, input logic [2:0] req);
        r_a = ia; r_b = ib; r_mode = im;
        #1;
        chk("ref_model", 32'({r_cbout, r_sum}), 32'(req));
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; start3 = 1'b0; fault = 0;
        r_a = '0; r_b = '0; r_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_vec",   32'({mode, a, b}), 32'd0);
        chk("reset_stat",  32'({busy, done, pass, fail_valid}), 32'd0);
        chk("reset_err",   32'(err_count), 32'd0);
        chk("reset_fvec",  32'(fail_vec), 32'd0);
        @(negedge clk) rst = 1'b0;

        // golden model: {cbout, sum}
        ref_chk(2'd3, 2'd3, 1'b0, 3'b110);
        ref_chk(2'd1, 2'd2, 1'b0, 3'b011);
        ref_chk(2'd1, 2'd2, 1'b1, 3'b111);
        ref_chk(2'd2, 2'd1, 1'b1, 3'b001);
        ref_chk(2'd0, 2'd0, 1'b1, 3'b000);

        // clean sweep
        push(64, 1'b1, 0, 1'b0, 5'b0_00_00);
        pulse_start();
        wait_done("timeout_clean");

        // sum[0] stuck at 0: every vector with odd result fails
        fault = 1;
        push(64, 1'b0, 16, 1'b1, 5'b0_00_01);
        pulse_start();
        wait_done("timeout_sum0");

        // start in DONE clears results at the next edge; start while busy is ignored
        fault = 0;
        push(64, 1'b1, 0, 1'b0, 5'b0_00_00);
        pulse_start();
        chk("restart_clear", 32'({busy, done, pass, fail_valid}), 32'b1000);
        chk("restart_err",   32'(err_count), 32'd0);
        chk("restart_fvec",  32'(fail_vec), 32'd0);
        repeat (20) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("busy_start_ignored", 32'(busy), 32'd1);
        wait_done("timeout_busy_start");

        // cbout inverted on subtract only
        fault = 2;
        push(64, 1'b0, 16, 1'b1, 5'b1_00_00);
        pulse_start();
        wait_done("timeout_cb");

        // reset mid-sweep at vector 10
        fault = 0;
        pulse_start();
        n = 0;
        while ({mode, a, b} !== 5'd10 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_vec10", 32'({mode, a, b}), 32'd10);
        #1 rst = 1'b1;
        #1;
        chk("abort_vec",  32'({mode, a, b}), 32'd0);
        chk("abort_stat", 32'({busy, done, pass, fail_valid}), 32'd0);
        chk("abort_err",  32'(err_count), 32'd0);
        @(negedge clk) rst = 1'b0;
        push(64, 1'b1, 0, 1'b0, 5'b0_00_00);
        pulse_start();
        wait_done("timeout_after_abort");

        // WIDTH=3, SETTLE_CYCLES=0: 128 vectors, one cycle each
        @(posedge clk); #1 start3 = 1'b1;
        @(posedge clk); #1 start3 = 1'b0;
        n = 0;
        while (done3 !== 1'b1 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("w3_latency",    32'(n), 32'd128);
        chk("w3_pass",       32'(pass3), 32'd1);
        chk("w3_err",        32'(err_count3), 32'd0);
        chk("w3_fail_valid", 32'(fail_valid3), 32'd0);

        repeat (3) @(posedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
